jtopl_mmr: RTL and testbench

CPU-facing register decoder that sits directly upstream of the operator/channel register file. It accepts OPL-style bus writes (address port, data port), decodes the OPL register map and drives the register file's group/subslot select, update strobes, the held data byte and the block/fnum-high latch. It also owns the global registers: timers, key-on, CSM and rhythm. It provides the status read-back.

---
 rtl/jtopl_mmr_if.sv | 12 +
 rtl/jtopl_mmr.sv | 186 ++++++++++++++++++
 tb/tb_jtopl_mmr.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/jtopl_mmr_if.sv
// CPU bus seen by the OPL register decoder: chip select, write strobe,
// port select, data in and the status byte read back.
interface jtopl_mmr_if;
   logic       cs_n;
   logic       wr_n;
   logic       addr;
   logic [7:0] din;
   logic [7:0] dout;

   modport master (output cs_n, wr_n, addr, din, input  dout);
   modport slave  (input  cs_n, wr_n, addr, din, output dout);
endinterface

// File: rtl/jtopl_mmr.sv
// OPL register-map decoder: turns CPU address/data port writes into register
// file selects and held update strobes, and owns timers, key-on, CSM and rhythm.
module jtopl_mmr #(
   parameter int HOLD = 18
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cen,
   jtopl_mmr_if.slave bus,
   input  logic       flag_A,
   input  logic       flag_B,
   output logic       busy,
   output logic [7:0] wr_data,
   output logic [1:0] sel_group,
   output logic [2:0] sel_sub,
   output logic       up_mult,
   output logic       up_ksl_tl,
   output logic       up_ar_dr,
   output logic       up_sl_rr,
   output logic       up_fnum,
   output logic       up_fbcon,
   output logic [4:0] latch_fnum,
   output logic [8:0] keyon,
   output logic [7:0] value_A,
   output logic [7:0] value_B,
   output logic       load_A,
   output logic       load_B,
   output logic       flagen_A,
   output logic       flagen_B,
   output logic       clr_flag,
   output logic       csm,
   output logic [7:0] rhythm
);

   localparam int CNT_W = $clog2(HOLD + 1);

   typedef enum logic {ST_IDLE, ST_HOLD} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [5:0]       up_q, up_nx;

   logic       wr_n_p0;
   logic [7:0] addr_q;
   logic [7:0] dout_q;
   logic       wr_ev, data_wr, strobe_wr;

   logic [5:0] dec_up;
   logic [1:0] dec_group;
   logic [2:0] dec_sub;
   logic       op_ok, ch_ok;

   // Channel 0..8 maps onto three groups of three subslots.
   function automatic logic [4:0] chan_sel(input logic [3:0] ch);
      logic [4:0] r;
      case (ch)
         4'd0, 4'd1, 4'd2: r = {2'd0, 3'(ch)};
         4'd3, 4'd4, 4'd5: r = {2'd1, 3'(ch - 4'd3)};
         4'd6, 4'd7, 4'd8: r = {2'd2, 3'(ch - 4'd6)};
         default:          r = 5'd0;
      endcase
      return r;
   endfunction

   // Write event: first clk sample of wr_n low while selected.
   assign wr_ev     = ~bus.cs_n & ~bus.wr_n & wr_n_p0;
   assign data_wr   = wr_ev & bus.addr;
   assign strobe_wr = data_wr & (|dec_up);

   always_comb begin
      dec_up    = 6'd0;
      dec_group = 2'd0;
      dec_sub   = 3'd0;
      op_ok     = (addr_q[7:5] >= 3'd1) && (addr_q[7:5] <= 3'd4) &&
                  (addr_q[4:3] != 2'd3) && (addr_q[2:0] <= 3'd5);
      ch_ok     = (addr_q[3:0] <= 4'd8);
      if (op_ok) begin
         dec_group = addr_q[4:3];
         dec_sub   = addr_q[2:0];
         case (addr_q[7:5])
            3'd1:    dec_up = 6'b000001;
            3'd2:    dec_up = 6'b000010;
            3'd3:    dec_up = 6'b000100;
            3'd4:    dec_up = 6'b001000;
            default: dec_up = 6'b000000;
         endcase
      end else if (ch_ok && (addr_q[7:4] == 4'hA || addr_q[7:4] == 4'hC)) begin
         {dec_group, dec_sub} = chan_sel(addr_q[3:0]);
         dec_up = (addr_q[7:4] == 4'hA) ? 6'b010000 : 6'b100000;
      end
   end

   // Strobe hold FSM: a new strobing write always restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
         up_q  <= 6'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         up_q  <= up_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      up_nx    = up_q;
      if (strobe_wr) begin
         state_nx = ST_HOLD;
         cnt_nx   = CNT_W'(HOLD);
         up_nx    = dec_up;
      end else if (state == ST_HOLD && cen) begin
         if (cnt <= CNT_W'(1)) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
            up_nx    = 6'd0;
         end else begin
            cnt_nx = cnt - CNT_W'(1);
         end
      end
   end

   assign busy = (state == ST_HOLD);
   assign {up_fbcon, up_fnum, up_sl_rr, up_ar_dr, up_ksl_tl, up_mult} = up_q;
   assign bus.dout = dout_q;

   // Bus capture, register-file data/select and global registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_n_p0    <= 1'b1;
         addr_q     <= 8'd0;
         wr_data    <= 8'd0;
         sel_group  <= 2'd0;
         sel_sub    <= 3'd0;
         latch_fnum <= 5'd0;
         keyon      <= 9'd0;
         value_A    <= 8'd0;
         value_B    <= 8'd0;
         load_A     <= 1'b0;
         load_B     <= 1'b0;
         flagen_A   <= 1'b0;
         flagen_B   <= 1'b0;
         clr_flag   <= 1'b0;
         csm        <= 1'b0;
         rhythm     <= 8'd0;
         dout_q     <= 8'd0;
      end else begin
         wr_n_p0 <= bus.wr_n;
         dout_q  <= {flag_A | flag_B, flag_A, flag_B, 5'd0};
         if (cen) clr_flag <= 1'b0;
         if (wr_ev && !bus.addr) addr_q <= bus.din;
         if (data_wr) begin
            wr_data <= bus.din;
            if (strobe_wr) begin
               sel_group <= dec_group;
               sel_sub   <= dec_sub;
            end
            if (addr_q[7:4] == 4'hB && ch_ok) begin
               latch_fnum            <= bus.din[4:0];
               keyon[addr_q[3:0]]    <= bus.din[5];
            end
            case (addr_q)
               8'h02: value_A <= bus.din;
               8'h03: value_B <= bus.din;
               8'h04: begin
                  // Flag reset is a pure command; it leaves masks and run bits alone.
                  if (bus.din[7]) begin
                     clr_flag <= 1'b1;
                  end else begin
                     flagen_A <= ~bus.din[6];
                     flagen_B <= ~bus.din[5];
                     load_B   <= bus.din[1];
                     load_A   <= bus.din[0];
                  end
               end
               8'h08:   csm    <= bus.din[7];
               8'hBD:   rhythm <= bus.din;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_jtopl_mmr.sv
// Directed bench for jtopl_mmr: register-map writes with hand-computed
// expectations for selects, strobe hold length, globals and status.
module tb_jtopl_mmr;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       cen;
   logic       flag_A, flag_B;
   logic       busy;
   logic [7:0] wr_data;
   logic [1:0] sel_group;
   logic [2:0] sel_sub;
   logic       up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_fnum, up_fbcon;
   logic [4:0] latch_fnum;
   logic [8:0] keyon;
   logic [7:0] value_A, value_B;
   logic       load_A, load_B, flagen_A, flagen_B, clr_flag, csm;
   logic [7:0] rhythm;
   logic [5:0] ups;

   int n_vec = 0;
   int n_err = 0;

   jtopl_mmr_if bus ();

   jtopl_mmr #(.HOLD(18)) dut (
      .clk(clk), .rst_n(rst_n), .cen(cen), .bus(bus),
      .flag_A(flag_A), .flag_B(flag_B), .busy(busy),
      .wr_data(wr_data), .sel_group(sel_group), .sel_sub(sel_sub),
      .up_mult(up_mult), .up_ksl_tl(up_ksl_tl), .up_ar_dr(up_ar_dr),
      .up_sl_rr(up_sl_rr), .up_fnum(up_fnum), .up_fbcon(up_fbcon),
      .latch_fnum(latch_fnum), .keyon(keyon),
      .value_A(value_A), .value_B(value_B), .load_A(load_A), .load_B(load_B),
      .flagen_A(flagen_A), .flagen_B(flagen_B), .clr_flag(clr_flag),
      .csm(csm), .rhythm(rhythm)
   );

   assign ups = {up_fbcon, up_fnum, up_sl_rr, up_ar_dr, up_ksl_tl, up_mult};

   always #5 clk = ~clk;

   // cen high every other cycle, changed away from both clock edges
   initial begin
      cen = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         cen = ~cen;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic a, input logic [7:0] d);
      @(negedge clk);
      bus.cs_n = 1'b0;
      bus.addr = a;
      bus.din  = d;
      bus.wr_n = 1'b0;
      @(negedge clk);
      bus.wr_n = 1'b1;
      bus.cs_n = 1'b1;
   endtask

   task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
      bus_write(1'b0, a);
      bus_write(1'b1, d);
   endtask

   // Called at a negedge; counts cen ticks while any strobe is high.
   task automatic count_strobe(output int ticks);
      ticks = 0;
      for (int i = 0; i < 200; i++) begin
         if (ups == 6'd0) break;
         if (cen) ticks++;
         @(negedge clk);
      end
   endtask

   int t;

   initial begin
      rst_n    = 1'b0;
      flag_A   = 1'b0;
      flag_B   = 1'b0;
      bus.cs_n = 1'b1;
      bus.wr_n = 1'b1;
      bus.addr = 1'b0;
      bus.din  = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_ups", 32'(ups), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_data", {wr_data, 3'(sel_sub), 2'(sel_group)}, 0);
      chk("rst_glob", {keyon, latch_fnum, load_A, load_B, flagen_A, flagen_B, clr_flag, csm}, 0);
      chk("rst_dout", 32'(bus.dout), 0);
      rst_n = 1'b1;

      // Operator write: ksl_tl, group 0, subslot 5
      write_reg(8'h45, 8'h3F);
      chk("op_ups", 32'(ups), 32'b000010);
      chk("op_sel", {sel_group, sel_sub}, {2'd0, 3'd5});
      chk("op_data", 32'(wr_data), 32'h3F);
      chk("op_busy", 32'(busy), 1);
      count_strobe(t);
      chk("op_ticks", t, 18);
      chk("op_busy_end", 32'(busy), 0);

      // Block/fnum latch with key-on, then fnum strobe on channel 7
      write_reg(8'hB7, 8'h35);
      chk("b7_keyon", 32'(keyon), 32'h080);
      chk("b7_latch", 32'(latch_fnum), 32'h15);
      chk("b7_nobusy", 32'(busy), 0);
      write_reg(8'hA7, 8'h80);
      chk("a7_ups", 32'(ups), 32'b010000);
      chk("a7_sel", {sel_group, sel_sub}, {2'd2, 3'd1});
      chk("a7_data", 32'(wr_data), 32'h80);
      count_strobe(t);
      chk("a7_ticks", t, 18);

      // Invalid slot and channel: data captured, nothing else moves
      write_reg(8'h26, 8'h5A);
      chk("inv26_ups", {busy, ups}, 0);
      chk("inv26_data", 32'(wr_data), 32'h5A);
      chk("inv26_sel", {sel_group, sel_sub}, {2'd2, 3'd1});
      write_reg(8'hA9, 8'hA5);
      chk("invA9_ups", {busy, ups}, 0);
      chk("invA9_data", 32'(wr_data), 32'hA5);

      // Timer and global registers
      write_reg(8'h02, 8'h9C);
      write_reg(8'h03, 8'h37);
      chk("values", {value_A, value_B}, 16'h9C37);
      write_reg(8'h04, 8'h43);
      chk("tctl", {load_A, load_B, flagen_A, flagen_B}, 4'b1101);
      write_reg(8'h04, 8'h80);
      chk("clr_rise", 32'(clr_flag), 1);
      t = 0;
      for (int i = 0; i < 50; i++) begin
         if (!clr_flag) break;
         if (cen) t++;
         @(negedge clk);
      end
      chk("clr_ticks", t, 1);
      chk("tctl_kept", {load_A, load_B, flagen_A, flagen_B}, 4'b1101);
      write_reg(8'h08, 8'h80);
      write_reg(8'hBD, 8'h2F);
      chk("csm_rhy", {csm, rhythm}, {1'b1, 8'h2F});
      chk("glob_nobusy", {busy, ups}, 0);

      // Status read-back
      flag_A = 1'b1;
      @(negedge clk);
      chk("dout_A", 32'(bus.dout), 32'hC0);
      flag_A = 1'b0;
      flag_B = 1'b1;
      @(negedge clk);
      chk("dout_B", 32'(bus.dout), 32'hA0);
      flag_B = 1'b0;
      @(negedge clk);
      chk("dout_0", 32'(bus.dout), 32'h00);

      // Restart: second strobing write mid-hold replaces the first
      write_reg(8'h21, 8'h11);
      chk("rs1_ups", 32'(ups), 32'b000001);
      chk("rs1_sel", {sel_group, sel_sub}, {2'd0, 3'd1});
      t = 0;
      for (int i = 0; i < 100 && t < 10; i++) begin
         if (cen) t++;
         @(negedge clk);
      end
      chk("rs1_held", 32'(ups), 32'b000001);
      write_reg(8'h60, 8'hF0);
      chk("rs2_ups", 32'(ups), 32'b000100);
      chk("rs2_sel", {sel_group, sel_sub, wr_data}, {2'd0, 3'd0, 8'hF0});
      count_strobe(t);
      chk("rs2_ticks", t, 18);
      chk("rs2_busy_end", 32'(busy), 0);

      // Asynchronous reset in the middle of a hold
      flag_A = 1'b1;
      write_reg(8'h40, 8'h01);
      chk("mid_ups", 32'(ups), 32'b000010);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_ups", {busy, ups}, 0);
      chk("arst_keyon", 32'(keyon), 0);
      chk("arst_dout", 32'(bus.dout), 0);
      chk("arst_glob", {csm, rhythm, wr_data}, 0);
      flag_A = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
